// File: rtl/booth_mult.sv
// Sequential radix-2 Booth signed multiplier: one recoded multiplier bit per clock,
// NBITS iterations per product, result registered on prod when busy falls.
module booth_mult #(
  parameter int MBITS = 16,
  parameter int NBITS = 16
) (
  output logic [MBITS+NBITS-1:0] prod,
  input  logic [MBITS-1:0]       mpd,
  input  logic [NBITS-1:0]       mpr,
  input  logic                   clk,
  output logic                   busy,
  input  logic                   start,
  input  logic                   reset
);

  localparam int CW = $clog2(NBITS + 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [MBITS:0]           a_q, a_d;
  logic [MBITS:0]           m_q, m_d;
  logic [NBITS-1:0]         q_q, q_d;
  logic                     qm1_q, qm1_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [MBITS+NBITS-1:0]   prod_q, prod_d;
  logic [MBITS:0]           sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    sum     = a_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          m_d     = {mpd[MBITS-1], mpd};
          a_d     = '0;
          q_d     = mpr;
          qm1_d   = 1'b0;
          cnt_d   = CW'(NBITS);
        end
      end
      RUN: begin
        unique case ({q_q[0], qm1_q})
          2'b01:   sum = a_q + m_q;
          2'b10:   sum = a_q - m_q;
          default: sum = a_q;
        endcase
        // Arithmetic right shift of {A, Q, Q-1}; A keeps one guard bit so -2^(MBITS-1) never overflows.
        a_d   = {sum[MBITS], sum[MBITS:1]};
        q_d   = {sum[0], q_q[NBITS-1:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          prod_d  = {a_d[MBITS-1:0], q_d};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign prod = prod_q;

endmodule

// File: tb/tb_booth_mult.sv
// Self-checking bench for booth_mult: directed corners plus random operands
// compared against plain signed multiplication.
module tb_booth_mult;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] mpd;
  logic [15:0] mpr;
  logic [31:0] prod;
  logic        busy;

  int unsigned n_checks;
  int unsigned n_fail;
  logic [31:0] prev;

  booth_mult #(.MBITS(16), .NBITS(16)) dut (
    .prod  (prod),
    .mpd   (mpd),
    .mpr   (mpr),
    .clk   (clk),
    .busy  (busy),
    .start (start),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] ea, eb;
    ea = $signed(a);
    eb = $signed(b);
    return ea * eb;
  endfunction

  // glitch_at: busy-cycle index at which a spurious start with new operands is pulsed (-1 = none)
  // reset_at : busy-cycle index at which reset is asserted mid-operation (-1 = none)
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input int glitch_at, input int reset_at);
    logic [31:0] exp;
    int          n;
    bit          aborted;
    exp = model(a, b);
    @(negedge clk);
    mpd   = a;
    mpr   = b;
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    n       = 0;
    aborted = 1'b0;
    while (busy && n < 40) begin
      check("hold_prev", {32'd0, prod}, {32'd0, prev});
      start = (n == glitch_at);
      if (n == glitch_at) begin
        mpd = 16'($urandom);
        mpr = 16'($urandom);
      end
      if (n == reset_at) begin
        #3 reset = 1'b1;
        #1;
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        check("async_rst_prod", {32'd0, prod}, 64'd0);
        @(negedge clk);
        reset   = 1'b0;
        prev    = '0;
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (!aborted) begin
      check("busy_len", 64'(n), 64'd16);
      check("prod", {32'd0, prod}, {32'd0, exp});
      prev = exp;
    end
  endtask

  task automatic run_held(input logic [15:0] a, input logic [15:0] b, input int ops);
    logic [31:0] exp;
    exp = model(a, b);
    @(negedge clk);
    mpd   = a;
    mpr   = b;
    start = 1'b1;
    for (int k = 0; k < 17 * ops; k++) begin
      @(negedge clk);
      check("held_busy", {63'd0, busy}, {63'd0, (k % 17) != 16});
      if ((k % 17) == 16)
        check("held_prod", {32'd0, prod}, {32'd0, exp});
    end
    start = 1'b0;
    for (int k = 0; k < 40 && busy; k++) @(negedge clk);
    check("held_drain", {63'd0, busy}, 64'd0);
    check("held_final", {32'd0, prod}, {32'd0, exp});
    prev = exp;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    prev     = '0;
    reset    = 1'b1;
    start    = 1'b0;
    mpd      = '0;
    mpr      = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_prod", {32'd0, prod}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", {63'd0, busy}, 64'd0);

    run_op(16'd10, 16'hFFF6, -1, -1);
    check("neg100", {32'd0, prod}, 64'hFFFF_FF9C);
    run_op(16'd10, 16'd10, -1, -1);
    check("pos100", {32'd0, prod}, 64'd100);
    run_op(16'h8000, 16'h8000, -1, -1);
    check("minxmin", {32'd0, prod}, 64'h4000_0000);
    run_op(16'h8000, 16'h7FFF, -1, -1);
    check("minxmax", {32'd0, prod}, 64'hC000_8000);
    run_op(16'd0, 16'hFFFF, -1, -1);
    run_op(16'hFFFF, 16'hFFFF, -1, -1);
    check("m1xm1", {32'd0, prod}, 64'd1);
    run_op(16'h7FFF, 16'h8000, -1, -1);

    run_op(16'd1234, 16'hFB2E, 5, -1);
    run_op(16'd77, 16'd99, -1, 8);
    run_op(16'hFF00, 16'd300, -1, -1);

    run_held(16'd321, 16'hFF85, 3);

    for (int i = 0; i < 20; i++)
      run_op(16'($urandom), 16'($urandom), -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
